// File: rtl/hist_writer.sv
// ---------------------------------------------------------------------------
// hist_writer
//
// Builds an 8-bit-per-bin histogram from a stream of bin indices, then writes
// it byte by byte into the histogram memory starting at a programmable base
// address. Bin counts saturate at 255, so every stored byte is a valid count.
//
// State | meaning
// ------+--------------------------------------------------------------------
// IDLE  | waiting for start; counters hold the previous histogram
// ACCUM | accepting bin beats, incrementing per-bin saturating counters
// FLUSH | one memory write per cycle, bins 0..NUM_BINS-1
// DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   start            in   begin a new histogram (sampled only in IDLE)
//   hist_addr_offset in   21-bit base byte address, latched with start
//   bin_valid        in   bin_idx valid this cycle
//   bin_idx          in   bin to increment (out-of-range indices dropped)
//   bin_last         in   final beat of the histogram (with bin_valid)
//   bin_ready        out  block accepts a bin this cycle (ACCUM only)
//   hist_addr        out  write address, base + bin, 21-bit wrap-around
//   hist_wen         out  write strobe, one byte per cycle
//   hist_wdata       out  byte written (bin count)
//   busy             out  high in every state except IDLE
//   done             out  one-cycle pulse after the final write
// ---------------------------------------------------------------------------
module hist_writer #(
    parameter int NUM_BINS = 256,
    parameter int BIN_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [20:0]      hist_addr_offset,
    input  logic             bin_valid,
    input  logic [BIN_W-1:0] bin_idx,
    input  logic             bin_last,
    output logic             bin_ready,
    output logic [20:0]      hist_addr,
    output logic             hist_wen,
    output logic [7:0]       hist_wdata,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(NUM_BINS);
    localparam logic [BIN_W:0] NB_LIM   = (BIN_W + 1)'(NUM_BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       cnt [NUM_BINS];
    logic [20:0]      base;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rem_cnt;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] bin_sel;
    logic             start_acc;
    logic             beat_acc;
    logic             last_acc;
    logic             in_range;
    logic [7:0]       first_byte;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign bin_ready = (state == S_ACCUM);
    assign busy      = (state != S_IDLE);
    assign start_acc = (state == S_IDLE) && start;
    assign beat_acc  = bin_ready && bin_valid;
    assign last_acc  = beat_acc && bin_last;
    assign in_range  = ({1'b0, bin_idx} < NB_LIM);
    assign bin_sel   = bin_idx[IDX_W-1:0];
    assign nxt_idx   = wr_idx + IDX_W'(1);

    // The bin_last beat lands in its counter on the same edge that launches
    // write 0, so byte 0 must see that beat through a bypass.
    assign first_byte = (in_range && (bin_sel == '0)) ? sat_inc(cnt[0]) : cnt[0];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ACCUM;
            S_ACCUM: if (bin_valid && bin_last) state_nxt = S_FLUSH;
            S_FLUSH: if (rem_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bin counters: cleared at start, no reset needed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_acc) begin
                for (int i = 0; i < NUM_BINS; i++) begin
                    cnt[i] <= '0;
                end
            end else if (beat_acc && in_range) begin
                cnt[bin_sel] <= sat_inc(cnt[bin_sel]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Base address and flush indexing. rem_cnt counts down the writes still
    // to issue after the current one; zero marks the final write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (start_acc) begin
            base <= hist_addr_offset;
        end
        if (last_acc) begin
            wr_idx  <= '0;
            rem_cnt <= LAST_IDX;
        end else if (state == S_FLUSH && rem_cnt != '0) begin
            wr_idx  <= nxt_idx;
            rem_cnt <= rem_cnt - IDX_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registered memory-write and done outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_wen   <= 1'b0;
            hist_addr  <= '0;
            hist_wdata <= '0;
            done       <= 1'b0;
        end else begin
            hist_wen <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_ACCUM: begin
                    if (last_acc) begin
                        hist_wen   <= 1'b1;
                        hist_addr  <= base;
                        hist_wdata <= first_byte;
                    end
                end
                S_FLUSH: begin
                    if (rem_cnt != '0) begin
                        hist_wen   <= 1'b1;
                        hist_addr  <= base + 21'(nxt_idx);
                        hist_wdata <= cnt[nxt_idx];
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_writer.sv
// ---------------------------------------------------------------------------
// tb_hist_writer
//
// Two instances share the bin stream: a 256-bin writer and a 200-bin writer
// (for out-of-range bin indices). Each has its own start; `sm` selects which
// one the current histogram run targets and which outputs are checked.
// Expected bytes come from a plain per-bin tally of the beats, clamped to 255.
// ---------------------------------------------------------------------------
module tb_hist_writer;

    localparam int NB_L = 256;
    localparam int NB_S = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_l = 1'b0;
    logic        start_s = 1'b0;
    logic [20:0] off = '0;
    logic        bin_valid = 1'b0;
    logic        bin_last = 1'b0;
    logic [7:0]  bin_idx = '0;

    logic        l_ready, l_wen, l_busy, l_done;
    logic [20:0] l_addr;
    logic [7:0]  l_wdata;
    logic        s_ready, s_wen, s_busy, s_done;
    logic [20:0] s_addr;
    logic [7:0]  s_wdata;

    logic        o_ready, o_wen, o_busy, o_done;
    logic [20:0] o_addr;
    logic [7:0]  o_wdata;

    int vectors = 0;
    int miscompares = 0;
    bit sm = 1'b0;
    int beats[$];

    always #5 clk = ~clk;

    hist_writer #(.NUM_BINS(NB_L), .BIN_W(8)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .hist_addr_offset(off),
        .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_last(bin_last),
        .bin_ready(l_ready), .hist_addr(l_addr), .hist_wen(l_wen),
        .hist_wdata(l_wdata), .busy(l_busy), .done(l_done)
    );

    hist_writer #(.NUM_BINS(NB_S), .BIN_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .hist_addr_offset(off),
        .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_last(bin_last),
        .bin_ready(s_ready), .hist_addr(s_addr), .hist_wen(s_wen),
        .hist_wdata(s_wdata), .busy(s_busy), .done(s_done)
    );

    always_comb begin
        o_ready = sm ? s_ready : l_ready;
        o_wen   = sm ? s_wen   : l_wen;
        o_busy  = sm ? s_busy  : l_busy;
        o_done  = sm ? s_done  : l_done;
        o_addr  = sm ? s_addr  : l_addr;
        o_wdata = sm ? s_wdata : l_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit v);
        if (sm) start_s = v;
        else    start_l = v;
    endtask

    // One histogram run over the beats queue. gap_pct: chance of an idle
    // cycle before each beat. noise: junk bins in IDLE/FLUSH and a start
    // pulse mid-FLUSH. abort_at: write index at which rst is applied (-1 none).
    task automatic run_hist(input logic [20:0] hbase, input int gap_pct,
                            input bit noise, input int abort_at);
        int n;
        int tally[256];
        int expv;
        int bad;
        logic [20:0] exp_addr;
        n = sm ? NB_S : NB_L;
        foreach (tally[i]) tally[i] = 0;
        foreach (beats[k]) if (beats[k] < n) tally[beats[k]]++;

        if (noise) begin
            repeat (3) begin
                bin_valid = 1'b1;
                bin_idx   = 8'($urandom_range(0, n - 1));
                bin_last  = 1'($urandom_range(0, 1));
                chk("idle_ready", 64'(o_ready), 64'(0));
                tick();
            end
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        chk("idle_busy", 64'(o_busy), 64'(0));

        off = hbase;
        pulse_start(1'b1);
        tick();
        pulse_start(1'b0);
        off = 21'($urandom);
        chk("accum_busy_ready", 64'({o_busy, o_ready}), 64'(2'b11));

        foreach (beats[k]) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bin_valid = 1'b0;
                bin_idx   = 8'($urandom);
                bin_last  = 1'($urandom_range(0, 1));
                tick();
            end
            bin_valid = 1'b1;
            bin_idx   = 8'(beats[k]);
            bin_last  = (k == beats.size() - 1);
            chk("beat_ready", 64'(o_ready), 64'(1));
            tick();
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;

        for (int i = 0; i < n; i++) begin
            expv     = (tally[i] > 255) ? 255 : tally[i];
            exp_addr = 21'((int'(hbase) + i) % (1 << 21));
            chk($sformatf("write%0d", i),
                64'({o_wen, o_ready, o_done, o_busy, o_addr, o_wdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b1, exp_addr, 8'(expv)}));
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_outputs", 64'({o_wen, o_busy, o_done}), 64'(0));
                bad = 0;
                repeat (n + 4) begin
                    tick();
                    if (o_done !== 1'b0 || o_wen !== 1'b0) bad++;
                end
                chk("abort_quiet", 64'(bad), 64'(0));
                return;
            end
            if (noise) begin
                bin_valid = 1'b1;
                bin_idx   = 8'($urandom_range(0, n - 1));
                bin_last  = 1'b1;
                if (i == 5) pulse_start(1'b1);
            end
            tick();
            bin_valid = 1'b0;
            bin_last  = 1'b0;
            pulse_start(1'b0);
        end

        chk("done_pulse", 64'({o_done, o_wen, o_busy, o_ready}), 64'(4'b1010));
        // start in the DONE cycle must be ignored
        pulse_start(1'b1);
        tick();
        pulse_start(1'b0);
        chk("idle_after_done", 64'({o_done, o_busy, o_ready, o_wen}), 64'(0));
    endtask

    initial begin
        int nb;
        repeat (3) tick();
        sm = 1'b0;
        chk("rst_large", 64'({o_wen, o_addr, o_wdata, o_busy, o_done, o_ready}), 64'(0));
        sm = 1'b1;
        chk("rst_small", 64'({o_wen, o_addr, o_wdata, o_busy, o_done, o_ready}), 64'(0));
        rst = 1'b0;
        sm  = 1'b0;
        tick();

        // basic build, with IDLE/FLUSH noise
        beats = '{3, 3, 7};
        run_hist(21'h000100, 0, 1'b1, -1);

        // same beats with valid gaps
        run_hist(21'h000100, 50, 1'b0, -1);

        // saturation
        beats.delete();
        repeat (300) beats.push_back(5);
        run_hist(21'h000000, 0, 1'b0, -1);

        // address wrap
        beats.delete();
        repeat (20) beats.push_back($urandom_range(0, NB_L - 1));
        run_hist(21'h1FFF80, 20, 1'b0, -1);

        // randomized histograms
        repeat (3) begin
            beats.delete();
            nb = $urandom_range(1, 60);
            repeat (nb) beats.push_back($urandom_range(0, NB_L - 1));
            run_hist(21'($urandom), 30, 1'b1, -1);
        end

        // reset mid-FLUSH, then a fresh single-beat histogram on bin 0
        beats.delete();
        repeat (15) beats.push_back($urandom_range(0, NB_L - 1));
        run_hist(21'h000200, 0, 1'b0, 10);
        beats = '{0};
        run_hist(21'h000200, 0, 1'b0, -1);

        // out-of-range bins on the 200-bin instance
        sm = 1'b1;
        beats = '{250, 1};
        run_hist(21'h000040, 0, 1'b0, -1);
        beats.delete();
        repeat (25) beats.push_back($urandom_range(0, 255));
        run_hist(21'($urandom), 25, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
